// File: rtl/btb_assoc_if.sv
// Fetch-lookup and resolved-branch update bundle for the set-associative BTB.
// master = fetch/execute side driving pc and updates, slave = the BTB itself.
interface btb_assoc_if #(
  parameter int WORD_W = 32
);
  logic [WORD_W-1:0] pc;
  logic              hit;
  logic              taken;
  logic [WORD_W-1:0] target;
  logic              WEN;
  logic [WORD_W-1:0] pc_w;
  logic [WORD_W-1:0] target_w;
  logic              taken_w;
  logic              flush;

  modport master (
    output pc, WEN, pc_w, target_w, taken_w, flush,
    input  hit, taken, target
  );
  modport slave (
    input  pc, WEN, pc_w, target_w, taken_w, flush,
    output hit, taken, target
  );
endinterface

// File: rtl/btb_assoc.sv
// Set-associative BTB: combinational lookup, 2-bit counter training on resolve,
// round-robin allocation on taken misses, single-cycle whole-table flush.
module btb_assoc #(
  parameter int SETS   = 4,
  parameter int WAYS   = 2,
  parameter int WORD_W = 32
) (
  input logic         CLK,
  input logic         RST,
  btb_assoc_if.slave  bus
);
  localparam int IDX   = $clog2(SETS);
  localparam int TAG_W = WORD_W - IDX - 2;
  localparam int WW    = (WAYS > 1) ? $clog2(WAYS) : 1;

  logic [SETS-1:0][WAYS-1:0]             valid;
  logic [SETS-1:0][WAYS-1:0][1:0]        cnt;
  logic [SETS-1:0][WAYS-1:0][TAG_W-1:0]  tag;
  logic [SETS-1:0][WAYS-1:0][WORD_W-1:0] tgt;
  logic [SETS-1:0][WW-1:0]               rr;

  logic [IDX-1:0]   r_idx, w_idx;
  logic [TAG_W-1:0] r_tag, w_tag;
  logic             w_hit, inv_found;
  logic [WW-1:0]    w_way, inv_way, victim;
  logic [1:0]       cnt_nxt;
  logic             unused_pc_lsb;

  assign r_idx = bus.pc[IDX+1:2];
  assign r_tag = bus.pc[WORD_W-1:IDX+2];
  assign w_idx = bus.pc_w[IDX+1:2];
  assign w_tag = bus.pc_w[WORD_W-1:IDX+2];
  assign unused_pc_lsb = &{1'b0, bus.pc[1:0], bus.pc_w[1:0]};

  // Allocation only happens on a miss, so at most one way can match here.
  always_comb begin
    bus.hit    = 1'b0;
    bus.taken  = 1'b0;
    bus.target = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid[r_idx][w] && tag[r_idx][w] == r_tag) begin
        bus.hit    = 1'b1;
        bus.taken  = cnt[r_idx][w][1];
        bus.target = tgt[r_idx][w];
      end
    end
  end

  // Descending scan leaves the lowest-index invalid way as the free slot.
  always_comb begin
    w_hit     = 1'b0;
    w_way     = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid[w_idx][w] && tag[w_idx][w] == w_tag) begin
        w_hit = 1'b1;
        w_way = w[WW-1:0];
      end
      if (!valid[w_idx][w]) begin
        inv_found = 1'b1;
        inv_way   = w[WW-1:0];
      end
    end
    victim = inv_found ? inv_way : rr[w_idx];
  end

  always_comb begin
    cnt_nxt = cnt[w_idx][w_way];
    if (bus.taken_w) begin
      if (cnt_nxt != 2'b11) cnt_nxt = cnt_nxt + 2'd1;
    end else begin
      if (cnt_nxt != 2'b00) cnt_nxt = cnt_nxt - 2'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      valid <= '0;
      cnt   <= '0;
      tag   <= '0;
      tgt   <= '0;
      rr    <= '0;
    end else if (bus.flush) begin
      valid <= '0;
      rr    <= '0;
    end else if (bus.WEN) begin
      if (w_hit) begin
        cnt[w_idx][w_way] <= cnt_nxt;
        if (bus.taken_w) tgt[w_idx][w_way] <= bus.target_w;
      end else if (bus.taken_w) begin
        valid[w_idx][victim] <= 1'b1;
        tag[w_idx][victim]   <= w_tag;
        tgt[w_idx][victim]   <= bus.target_w;
        cnt[w_idx][victim]   <= 2'b10;
        if (!inv_found && WAYS > 1) rr[w_idx] <= rr[w_idx] + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_btb_assoc.sv
// Directed bench for btb_assoc (SETS=4, WAYS=2): lookups are sampled in the low
// clock phase, expected {hit,taken,target} values are hand-computed.
module tb_btb_assoc;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  btb_assoc_if #(.WORD_W(32)) bus ();

  btb_assoc #(.SETS(4), .WAYS(2), .WORD_W(32)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected value packing: {hit, taken, target}.
  function automatic logic [63:0] ex(input logic h, input logic t, input logic [31:0] tg);
    return {30'd0, h, t, tg};
  endfunction

  task automatic look(input string tag, input logic [31:0] p, input logic [63:0] exp);
    bus.pc = p;
    #1;
    chk(tag, {30'd0, bus.hit, bus.taken, bus.target}, exp);
  endtask

  task automatic upd(input logic [31:0] p, input logic [31:0] t, input logic tk);
    @(negedge CLK);
    bus.WEN = 1'b1; bus.pc_w = p; bus.target_w = t; bus.taken_w = tk;
    @(negedge CLK);
    bus.WEN = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
  endtask

  initial begin
    bus.pc = '0; bus.WEN = 1'b0; bus.pc_w = '0; bus.target_w = '0;
    bus.taken_w = 1'b0; bus.flush = 1'b0;

    // Reset / empty sweep
    do_reset();
    for (int i = 0; i < 16; i++) look("rst_sweep", 32'(i * 4), ex(0, 0, 0));

    // Allocate and train 0x40 (set 0)
    upd(32'h40, 32'h100, 1); look("alloc_40", 32'h40, ex(1, 1, 32'h100));
    upd(32'h40, 32'h0, 0);   look("dec_01", 32'h40, ex(1, 0, 32'h100));
    upd(32'h40, 32'h0, 0);   look("dec_00", 32'h40, ex(1, 0, 32'h100));
    upd(32'h40, 32'h100, 1); look("inc_01", 32'h40, ex(1, 0, 32'h100));
    upd(32'h40, 32'h100, 1); look("inc_10", 32'h40, ex(1, 1, 32'h100));
    upd(32'h40, 32'h100, 1); look("inc_11", 32'h40, ex(1, 1, 32'h100));
    upd(32'h40, 32'h100, 1); look("sat_11", 32'h40, ex(1, 1, 32'h100));
    upd(32'h40, 32'h0, 0);   look("sat_dec_10", 32'h40, ex(1, 1, 32'h100));
    upd(32'h40, 32'h0, 0);   look("sat_dec_01", 32'h40, ex(1, 0, 32'h100));

    // Target rewrite only on taken
    upd(32'h40, 32'h200, 1); look("tgt_rewrite", 32'h40, ex(1, 1, 32'h200));
    upd(32'h40, 32'h300, 0); look("tgt_keep", 32'h40, ex(1, 0, 32'h200));

    // Not-taken miss allocates nothing
    upd(32'h80, 32'h500, 0);
    look("nt_miss", 32'h80, ex(0, 0, 0));
    look("nt_miss_40", 32'h40, ex(1, 0, 32'h200));

    // Same-cycle lookup and update: old state now, new state next cycle
    bus.pc = 32'h40;
    @(negedge CLK);
    bus.WEN = 1'b1; bus.pc_w = 32'h40; bus.target_w = 32'h400; bus.taken_w = 1'b1;
    look("coll_old", 32'h40, ex(1, 0, 32'h200));
    @(negedge CLK);
    bus.WEN = 1'b0;
    look("coll_new", 32'h40, ex(1, 1, 32'h400));

    // Replacement in set 0
    do_reset();
    upd(32'h00, 32'h1000, 1);
    upd(32'h10, 32'h1010, 1);
    upd(32'h20, 32'h1020, 1);
    look("repl_ev00", 32'h00, ex(0, 0, 0));
    look("repl_10", 32'h10, ex(1, 1, 32'h1010));
    look("repl_20", 32'h20, ex(1, 1, 32'h1020));
    upd(32'h30, 32'h1030, 1);
    look("repl_ev10", 32'h10, ex(0, 0, 0));
    look("repl_20b", 32'h20, ex(1, 1, 32'h1020));
    look("repl_30", 32'h30, ex(1, 1, 32'h1030));
    upd(32'h00, 32'h2000, 1);
    look("repl_ev20", 32'h20, ex(0, 0, 0));
    look("repl_30b", 32'h30, ex(1, 1, 32'h1030));
    look("repl_00", 32'h00, ex(1, 1, 32'h2000));

    // Flush with WEN: update dropped, table empty, rr cleared
    @(negedge CLK);
    bus.flush = 1'b1; bus.WEN = 1'b1; bus.pc_w = 32'h44; bus.target_w = 32'h4400; bus.taken_w = 1'b1;
    @(negedge CLK);
    bus.flush = 1'b0; bus.WEN = 1'b0;
    look("flush_00", 32'h00, ex(0, 0, 0));
    look("flush_30", 32'h30, ex(0, 0, 0));
    look("flush_44", 32'h44, ex(0, 0, 0));
    upd(32'h10, 32'h3010, 1);
    upd(32'h20, 32'h3020, 1);
    upd(32'h60, 32'h3060, 1);
    look("flush_rr_10", 32'h10, ex(0, 0, 0));
    look("flush_rr_20", 32'h20, ex(1, 1, 32'h3020));
    look("flush_rr_60", 32'h60, ex(1, 1, 32'h3060));

    // RST in the middle of a back-to-back WEN burst
    for (int i = 1; i <= 3; i++) begin
      @(negedge CLK);
      bus.WEN = 1'b1; bus.pc_w = 32'(i * 4); bus.target_w = 32'(32'h5000 + i); bus.taken_w = 1'b1;
    end
    @(negedge CLK);
    bus.pc_w = 32'h48; bus.target_w = 32'h5048;
    look("burst_0c", 32'h0C, ex(1, 1, 32'h5003));
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0; bus.WEN = 1'b0;
    look("rst_burst_04", 32'h04, ex(0, 0, 0));
    look("rst_burst_0c", 32'h0C, ex(0, 0, 0));
    look("rst_burst_48", 32'h48, ex(0, 0, 0));
    look("rst_burst_20", 32'h20, ex(0, 0, 0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/btb_assoc.md
# btb_assoc

Parametrised set-associative branch target buffer that replaces the fixed 4-entry BTB in the fetch stage. The fetch stage presents the current PC and gets a hit/taken/target prediction in the same cycle. The execute/memory stage writes back resolved branch outcomes, which train a 2-bit saturating counter per entry and allocate new entries with round-robin replacement. A single-cycle flush invalidates the whole table, for context switch or coherence events.

## Interface
Parameters:
- SETS, 4: number of sets; power of 2, ≥2
- WAYS, 2: ways per set; power of 2, ≥1
- WORD_W, 32: PC/target width (matches word_t)

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- pc  in  WORD_W  fetch PC to look up
- hit  out  1  valid entry matching pc exists
- taken  out  1  predict taken (hit & counter MSB)
- target  out  WORD_W  predicted target; 0 when !hit
- WEN  in  1  resolved-branch update strobe
- pc_w  in  WORD_W  PC of resolved branch
- target_w  in  WORD_W  resolved target
- taken_w  in  1  resolved outcome
- flush  in  1  invalidate all entries

## Operation
- Address split: IDX = log2(SETS) bits. Index = pc[IDX+1:2]; tag = pc[WORD_W-1:IDX+2]; pc[1:0] is ignored. pc_w uses the same split.
- Each entry holds: valid, tag, cnt[1:0], target. cnt encoding: 11 = strong taken, 10 = weak taken, 01 = weak not-taken, 00 = strong not-taken.
- Each set holds a round-robin victim pointer rr of log2(WAYS) bits, or none if WAYS=1.
- Lookup is combinational.
  - hit = OR over ways of (valid & tag match).
  - taken = hit & cnt[1] of the matching way.
  - target = the matching way's target, else 0.
  - At most one way ever matches, because allocation only occurs on a miss.
- Update, when WEN=1 at a clock edge:
  - Hit in the set of pc_w:
    - cnt saturating increment if taken_w, else saturating decrement (floor 00, ceiling 11).
    - If taken_w, target ← target_w, which covers jr/indirect targets.
    - rr is unchanged.
  - Miss with taken_w=1: allocate.
    - Victim is the lowest-index invalid way. If no way is invalid, the victim is way rr and rr ← rr+1 mod WAYS.
    - Write valid=1, tag, target=target_w, cnt=10.
  - Miss with taken_w=0: no state change. Never-taken branches are not allocated.
- Flush: all valid ← 0 and all rr ← 0. Tags, targets and counters keep their values and are don't-care.
- Priority: RST > flush > WEN. If WEN coincides with flush, the update is dropped.

## Timing
- Reset values: every valid=0, cnt=00, target=0, tag=0, rr=0. Outputs after reset: hit=0, taken=0, target=0 for any pc.
- Lookup latency is 0 cycles; outputs are purely combinational from pc and state.
- Update latency: the write commits at the edge where WEN=1 and is visible to lookup in the following cycle.
- Same-cycle lookup and update to the same entry: lookup returns pre-update state. There is no write-through bypass.
- Flush with WEN=1 in the same cycle: table is empty next cycle and nothing is allocated.
- RST asserted mid-operation: the state is cleared at that edge regardless of WEN or flush.
- No handshake; WEN is a single-cycle strobe and back-to-back updates every cycle are legal.
- A stalled fetch simply holds pc, and the outputs track state changes.

## Test plan
- **Reset/empty:** assert RST 2 cycles, then sweep pc = 0x0000_0000 … 0x0000_003C -> hit=0, taken=0, target=0 for every pc.
- **Allocate and train:**
  - WEN, pc_w=0x0000_0040, target_w=0x0000_0100, taken_w=1 -> next cycle pc=0x40 gives hit=1, taken=1, target=0x100 (cnt=10).
  - Then 2× taken_w=0 -> cnt=00, taken=0, hit=1.
  - Then 3× taken_w=1 -> cnt=11.
  - A 4th taken_w=1 stays saturated at 11.
- **Not-taken miss:** WEN, pc_w=0x0000_0080, taken_w=0 on an empty table -> pc=0x80 gives hit=0, and no valid bit changes.
- **Replacement** (SETS=4, WAYS=2):
  - Allocate taken branches at 0x00, 0x10, 0x20, all in set 0 -> 0x00 is evicted (way 0) and rr=1.
  - Then allocate 0x30 -> 0x10 is evicted and rr=0.
  - 0x20 and 0x30 hit.
- **Target rewrite:** entry 0x40→0x100, then WEN with taken_w=1, target_w=0x0000_0200 -> target=0x200 next cycle. A later update with taken_w=0 and target_w=0x300 leaves target=0x200.
- **Same-cycle collisions:**
  - Lookup pc=0x40 while WEN updates 0x40 -> old values that cycle, new values the next.
  - flush and WEN in the same cycle -> all hit=0 afterwards.
  - RST during a WEN burst -> table empty.
